// File: rtl/cpu_pkg.sv
// Shared decode constants, ALU op encoding and the DX control bundle.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RIDX = 5;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BGT   = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;
    localparam logic [5:0] FN_MUL = 6'd24;
    localparam logic [5:0] FN_DIV = 6'd26;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_MUL = 4'd5,
        ALU_DIV = 4'd6
    } alu_op_e;

    // Control carried from decode into the DX register; all-zero is a bubble.
    typedef struct packed {
        logic            valid;
        alu_op_e         alu_op;
        logic            alu_src;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            beq;
        logic            bne;
        logic            bgt;
        logic [RIDX-1:0] rd;
    } ctrl_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
        return {{(XLEN-16){v[15]}}, v};
    endfunction
endpackage

// File: rtl/reg_file.sv
// 32x32 register file, two read ports, one write port.
// Reads are write-first so a same-cycle write-back reaches decode; r0 is hardwired to zero.
module reg_file
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [RIDX-1:0] ra1_i,
    input  logic [RIDX-1:0] ra2_i,
    input  logic            we_i,
    input  logic [RIDX-1:0] wa_i,
    input  logic [XLEN-1:0] wd_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);
    logic [XLEN-1:0] regs_q [NREG];

    // Storage update; writes to r0 are dropped so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Read ports with write-back bypass.
    always_comb begin
        rd1_o = regs_q[ra1_i];
        rd2_o = regs_q[ra2_i];
        if (we_i && (wa_i == ra1_i)) rd1_o = wd_i;
        if (we_i && (wa_i == ra2_i)) rd2_o = wd_i;
        if (ra1_i == '0) rd1_o = '0;
        if (ra2_i == '0) rd2_o = '0;
    end
endmodule

// File: rtl/instruction_decode.sv
// ID stage: decodes IR, reads operands, detects load-use hazards and fills the DX pipeline register.
module instruction_decode
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     PC,
    input  logic [31:0]     IR,
    input  logic            bnoWB,
    input  logic            jnoWB,
    input  logic            ex_taken,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [31:0]     wb_data,
    output logic            en,
    output logic            jump,
    output logic [27:0]     address,
    output logic [31:0]     FD_PC,
    output logic [31:0]     DX_PC,
    output logic [31:0]     offset,
    output logic            beq,
    output logic            bne,
    output logic            bgt,
    output logic [31:0]     dx_rs_val,
    output logic [31:0]     dx_rt_val,
    output logic [31:0]     dx_imm,
    output logic [3:0]      dx_alu_op,
    output logic            dx_alu_src,
    output logic [4:0]      dx_rd,
    output logic            dx_reg_write,
    output logic            dx_mem_read,
    output logic            dx_mem_write,
    output logic            dx_valid
);
    logic [5:0]      op, funct;
    logic [4:0]      rs, rt, rd_f;
    logic [XLEN-1:0] imm_sext, rs_val, rt_val;
    ctrl_t           dec;
    logic            dec_reads_rt;
    logic            squash, hazard, bubble;

    ctrl_t           dx_ctrl_q, dx_ctrl_d;
    logic [XLEN-1:0] dx_pc_q, dx_pc_d, dx_rs_q, dx_rs_d, dx_rt_q, dx_rt_d, dx_imm_q, dx_imm_d;

    assign op       = IR[31:26];
    assign rs       = IR[25:21];
    assign rt       = IR[20:16];
    assign rd_f     = IR[15:11];
    assign funct    = IR[5:0];
    assign imm_sext = sext16(IR[15:0]);

    reg_file u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs),
        .ra2_i (rt),
        .we_i  (wb_we),
        .wa_i  (wb_addr),
        .wd_i  (wb_data),
        .rd1_o (rs_val),
        .rd2_o (rt_val)
    );

    // Opcode/funct decode; anything unrecognised (including IR=0) leaves dec as a bubble.
    always_comb begin
        dec          = '0;
        dec_reads_rt = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                dec.valid     = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = rd_f;
                dec_reads_rt  = 1'b1;
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_MUL:  dec.alu_op = ALU_MUL;
                    FN_DIV:  dec.alu_op = ALU_DIV;
                    default: begin
                        dec          = '0;
                        dec_reads_rt = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_LW: begin
                dec.valid     = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.mem_read  = (op == OP_LW);
                dec.rd        = rt;
            end
            OP_SW: begin
                dec.valid     = 1'b1;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.rd        = rt;
                dec_reads_rt  = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BGT: begin
                dec.valid    = 1'b1;
                dec.alu_op   = ALU_SUB;
                dec.beq      = (op == OP_BEQ);
                dec.bne      = (op == OP_BNE);
                dec.bgt      = (op == OP_BGT);
                dec.rd       = rt;
                dec_reads_rt = 1'b1;
            end
            OP_J: dec.valid = 1'b1;
            default: ;
        endcase
    end

    // Hazard/squash resolution and the fetch-facing combinational outputs.
    always_comb begin
        squash  = bnoWB | jnoWB | ex_taken;
        hazard  = dx_ctrl_q.valid & dx_ctrl_q.mem_read & (dx_ctrl_q.rd != '0) &
                  ((dx_ctrl_q.rd == rs) | ((dx_ctrl_q.rd == rt) & dec_reads_rt));
        bubble  = squash | hazard | ~dec.valid;
        en      = ~(hazard & ~ex_taken);
        jump    = (op == OP_J) & ~hazard & ~squash;
        address = {IR[25:0], 2'b00};
        FD_PC   = PC;
    end

    // Next DX contents: either the decoded instruction or an all-zero bubble.
    always_comb begin
        dx_ctrl_d = '0;
        dx_pc_d   = '0;
        dx_rs_d   = '0;
        dx_rt_d   = '0;
        dx_imm_d  = '0;
        if (!bubble) begin
            dx_ctrl_d = dec;
            dx_pc_d   = PC;
            dx_rs_d   = rs_val;
            dx_rt_d   = rt_val;
            dx_imm_d  = imm_sext;
        end
    end

    // DX pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dx_ctrl_q <= '0;
            dx_pc_q   <= '0;
            dx_rs_q   <= '0;
            dx_rt_q   <= '0;
            dx_imm_q  <= '0;
        end else begin
            dx_ctrl_q <= dx_ctrl_d;
            dx_pc_q   <= dx_pc_d;
            dx_rs_q   <= dx_rs_d;
            dx_rt_q   <= dx_rt_d;
            dx_imm_q  <= dx_imm_d;
        end
    end

    assign DX_PC        = dx_pc_q;
    assign offset       = {dx_imm_q[29:0], 2'b00};
    assign beq          = dx_ctrl_q.beq;
    assign bne          = dx_ctrl_q.bne;
    assign bgt          = dx_ctrl_q.bgt;
    assign dx_rs_val    = dx_rs_q;
    assign dx_rt_val    = dx_rt_q;
    assign dx_imm       = dx_imm_q;
    assign dx_alu_op    = dx_ctrl_q.alu_op;
    assign dx_alu_src   = dx_ctrl_q.alu_src;
    assign dx_rd        = dx_ctrl_q.rd;
    assign dx_reg_write = dx_ctrl_q.reg_write;
    assign dx_mem_read  = dx_ctrl_q.mem_read;
    assign dx_mem_write = dx_ctrl_q.mem_write;
    assign dx_valid     = dx_ctrl_q.valid;
endmodule
